// File: rtl/ex_div.sv
// Iterative RV32M divider: one restoring step per cycle, 32 cycles per operation.
// Raises a combinational stall request while a divide is pending or running.
module ex_div (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        annul_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [63:0] rem_q, rem_d;
  logic        sgn_quo_q, sgn_quo_d;
  logic        sgn_rem_q, sgn_rem_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  // Operand magnitudes; op_i[0] set means unsigned (DIVU/REMU).
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~op_i[0] & dividend_i[31];
    b_neg = ~op_i[0] & divisor_i[31];
    a_mag = a_neg ? (32'd0 - dividend_i) : dividend_i;
    b_mag = b_neg ? (32'd0 - divisor_i) : divisor_i;
  end

  // Restoring step: upper half holds the partial remainder, lower half shifts
  // dividend bits out and quotient bits in.
  logic [32:0] part;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] rem_step;
  logic [31:0] quo_mag, rmd_mag, quo_fix, rmd_fix, final_res;

  always_comb begin
    part     = rem_q[63:31];
    fits     = part >= {1'b0, dvsr_q};
    diff     = part[31:0] - dvsr_q;
    rem_step = fits ? {diff, rem_q[30:0], 1'b1} : {rem_q[62:0], 1'b0};
    quo_mag  = rem_step[31:0];
    rmd_mag  = rem_step[63:32];
    quo_fix  = (sgn_quo_q & ~op_q[0]) ? (32'd0 - quo_mag) : quo_mag;
    rmd_fix  = (sgn_rem_q & ~op_q[0]) ? (32'd0 - rmd_mag) : rmd_mag;
    final_res = op_q[1] ? rmd_fix : quo_fix;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    op_d      = op_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          if (divisor_i != 32'd0) begin
            state_d   = StCalc;
            cnt_d     = 5'd0;
            dvsr_d    = b_mag;
            rem_d     = {32'd0, a_mag};
            sgn_quo_d = dividend_i[31] ^ divisor_i[31];
            sgn_rem_d = dividend_i[31];
            op_d      = op_i;
          end else begin
            state_d  = StDone;
            result_d = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
          end
        end
      end
      StCalc: begin
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = final_res;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // An annulled operation never reaches DONE, so the result must not move.
    if (annul_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      dvsr_q    <= 32'd0;
      rem_q     <= 64'd0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      op_q      <= 2'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      op_q      <= op_d;
      result_q  <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == StDone);
  assign stallreq_o = ~RST & ~annul_i &
                      (((state_q == StIdle) & start_i) | (state_q == StCalc));

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes model results, a negedge monitor
// pops and compares whenever ready_o is seen.
module tb_ex_div;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  ex_div dut (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (start_i),
    .op_i      (op_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // RV32M semantics in plain arithmetic.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (op[1]) return $unsigned($signed(a) % $signed(b));
    return $unsigned($signed(a) / $signed(b));
  endfunction

  always @(negedge CLK) begin
    if (!RST && ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got result 0x%08h expected no ready pulse", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the DONE->IDLE edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input string tag);
    int stalls;
    int waited;
    bit got;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(negedge CLK);
    check({tag, "_stall_c0"}, 32'(stallreq_o), 32'd1);
    check({tag, "_ready_c0"}, 32'(ready_o), 32'd0);
    stalls = 1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 40) begin
      @(negedge CLK);
      waited++;
      if (ready_o) got = 1'b1;
      else if (stallreq_o) stalls++;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s_timeout: got no ready in 40 cycles expected ready", tag);
      exp_q.delete();
    end else begin
      check({tag, "_latency"}, 32'(stalls), 32'(lat));
      check({tag, "_stall_done"}, 32'(stallreq_o), 32'd0);
    end
    @(posedge CLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge CLK);
    check({tag, "_idle_ready"}, 32'(ready_o), 32'd0);
    check({tag, "_idle_stall"}, 32'(stallreq_o), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST        = 1'b1;
    start_i    = 1'b0;
    annul_i    = 1'b0;
    op_i       = 2'd0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", result_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    RST = 1'b0;
    idle_cycle("post_rst");

    run_op(2'b01, 32'd100, 32'd7, 33, "divu_100_7");
    idle_cycle("after_divu");
    run_op(2'b11, 32'd100, 32'd7, 33, "remu_100_7");
    run_op(2'b10, -32'sd7, 32'd2, 33, "rem_m7_2");
    run_op(2'b00, -32'sd7, 32'd2, 33, "div_m7_2");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, "rem_ovf");
    run_op(2'b01, 32'd5, 32'd0, 1, "divu_5_0");
    run_op(2'b11, 32'd5, 32'd0, 1, "remu_5_0");
    run_op(2'b00, 32'hFFFF_FFFF, 32'd0, 1, "div_m1_0");
    idle_cycle("after_dz");

    // Annul on the 10th CALC cycle; nothing is pushed so any ready is flagged.
    op_i       = 2'b01;
    dividend_i = 32'hFFFF_FFFF;
    divisor_i  = 32'd3;
    start_i    = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    annul_i = 1'b1;
    @(negedge CLK);
    check("annul_stall", 32'(stallreq_o), 32'd0);
    @(posedge CLK);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) idle_cycle("after_annul");
    run_op(2'b01, 32'd9, 32'd3, 33, "divu_9_3");

    run_op(2'b01, 32'd50, 32'd5, 33, "b2b_divu");
    run_op(2'b11, 32'd50, 32'd6, 33, "b2b_remu");

    // Reset mid-CALC.
    op_i       = 2'b00;
    dividend_i = 32'd1234567;
    divisor_i  = 32'd89;
    start_i    = 1'b1;
    repeat (6) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_stall", 32'(stallreq_o), 32'd0);
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    RST     = 1'b0;
    repeat (2) idle_cycle("after_midrst");

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) b = 32'hFFFF_FFFF;
      else b = $urandom;
      if (sel == 1 && (i % 2) == 0) a = 32'h8000_0000;
      run_op(op, a, b, (b == 32'd0) ? 1 : 33, "rand");
      repeat ($urandom_range(0, 2)) idle_cycle("rand_gap");
    end

    repeat (3) idle_cycle("final");
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
